// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : capture_sequencer
// Purpose  : Capture-flow controller. Streams qualified samples into the
//            sample memory once armed, counts a programmed number of
//            post-trigger samples after run, then reads a programmed number
//            of words back and hands them to the transmitter over a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   wrSize/config_data load {delayCount, readCount} (IDLE only)
//   arm                start a capture (IDLE only)
//   run                trigger hit (SAMPLE only)
//   sti_valid/sti_data incoming sample stream
//   mem_wr/mem_wdata   sample memory write strobe and data (1-cycle latency)
//   mem_rd/mem_rdata   sample memory read strobe; data returns 1 cycle later
//   tx_valid/tx_data   readback word towards the transmitter
//   tx_ready           transmitter accepts the current word
//   busy               high in every state except IDLE
//   abort              (CAPTURE_SEQUENCER_ABORT_EN only) force IDLE
// Build option:
//   CAPTURE_SEQUENCER_ABORT_EN adds the abort input port.
// ============================================================================
module capture_sequencer #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
`ifdef CAPTURE_SEQUENCER_ABORT_EN
  input  logic          abort,
`endif
  input  logic          wrSize,
  input  logic [31:0]   config_data,
  input  logic          arm,
  input  logic          run,
  input  logic          sti_valid,
  input  logic [DW-1:0] sti_data,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ready,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    DELAY  = 3'd2,
    READ   = 3'd3,
    RDWAIT = 3'd4,
    XMIT   = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] delay_count, delay_count_nxt;
  logic [CW-1:0] read_count, read_count_nxt;
  logic [CW-1:0] delay_cnt, delay_cnt_nxt;
  logic [CW-1:0] rd_cnt, rd_cnt_nxt;
  logic          mem_wr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          mem_rd_nxt;
  logic          tx_valid_nxt;
  logic [DW-1:0] tx_data_nxt;
  logic          busy_nxt;
  logic          abort_req;

`ifdef CAPTURE_SEQUENCER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      delay_count <= '0;
      read_count  <= '0;
      delay_cnt   <= '0;
      rd_cnt      <= '0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      mem_rd      <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      delay_count <= delay_count_nxt;
      read_count  <= read_count_nxt;
      delay_cnt   <= delay_cnt_nxt;
      rd_cnt      <= rd_cnt_nxt;
      mem_wr      <= mem_wr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      mem_rd      <= mem_rd_nxt;
      tx_valid    <= tx_valid_nxt;
      tx_data     <= tx_data_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    delay_count_nxt = delay_count;
    read_count_nxt  = read_count;
    delay_cnt_nxt   = delay_cnt;
    rd_cnt_nxt      = rd_cnt;
    mem_wr_nxt      = 1'b0;
    mem_wdata_nxt   = mem_wdata;
    mem_rd_nxt      = 1'b0;
    tx_valid_nxt    = tx_valid;
    tx_data_nxt     = tx_data;

    unique case (state)
      IDLE: begin
        if (wrSize) begin
          read_count_nxt  = config_data[CW-1:0];
          delay_count_nxt = config_data[CW+15:16];
        end
        if (arm) begin
          state_nxt     = SAMPLE;
          delay_cnt_nxt = '0;
          rd_cnt_nxt    = '0;
        end
      end

      SAMPLE: begin
        if (sti_valid) begin
          mem_wr_nxt    = 1'b1;
          mem_wdata_nxt = sti_data;
        end
        if (run) begin
          // A valid sample in the trigger cycle is post-trigger sample 0,
          // so with delayCount=0 the capture is already complete here.
          if (sti_valid && (delay_cnt == delay_count)) begin
            state_nxt  = READ;
            mem_rd_nxt = 1'b1;
          end else begin
            state_nxt = DELAY;
            if (sti_valid) begin
              delay_cnt_nxt = delay_cnt + CNT_ONE;
            end
          end
        end
      end

      DELAY: begin
        if (sti_valid) begin
          mem_wr_nxt    = 1'b1;
          mem_wdata_nxt = sti_data;
          if (delay_cnt == delay_count) begin
            state_nxt  = READ;
            mem_rd_nxt = 1'b1;
          end else begin
            delay_cnt_nxt = delay_cnt + CNT_ONE;
          end
        end
      end

      // mem_rd is raised on entry so that it is high during the READ cycle;
      // the memory returns data during RDWAIT, which is captured at its end.
      READ: begin
        state_nxt = RDWAIT;
      end

      RDWAIT: begin
        tx_data_nxt  = mem_rdata;
        tx_valid_nxt = 1'b1;
        state_nxt    = XMIT;
      end

      XMIT: begin
        if (tx_ready && tx_valid) begin
          tx_valid_nxt = 1'b0;
          if (rd_cnt == read_count) begin
            state_nxt = IDLE;
          end else begin
            rd_cnt_nxt = rd_cnt + CNT_ONE;
            state_nxt  = READ;
            mem_rd_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort overrides everything decided above; size fields are kept.
    if (abort_req) begin
      state_nxt     = IDLE;
      mem_wr_nxt    = 1'b0;
      mem_rd_nxt    = 1'b0;
      tx_valid_nxt  = 1'b0;
      delay_cnt_nxt = '0;
      rd_cnt_nxt    = '0;
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_sequencer
// Purpose  : Directed self-checking bench for capture_sequencer (CW=4 build).
//            A small memory model returns 0xA5A5_0000 + read index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrSize = 1'b0;
  logic [31:0]   config_data = '0;
  logic          arm = 1'b0;
  logic          run = 1'b0;
  logic          sti_valid = 1'b0;
  logic [DW-1:0] sti_data = '0;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata = '0;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready = 1'b0;
  logic          busy;
`ifdef CAPTURE_SEQUENCER_ABORT_EN
  logic          abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic [DW-1:0] wr_last = '0;
  logic [DW-1:0] acc_words[$];
  int unsigned   rptr = 0;

  int w0, r0, a0;

  capture_sequencer #(.DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef CAPTURE_SEQUENCER_ABORT_EN
    .abort       (abort),
`endif
    .wrSize      (wrSize),
    .config_data (config_data),
    .arm         (arm),
    .run         (run),
    .sti_valid   (sti_valid),
    .sti_data    (sti_data),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears one cycle after the mem_rd strobe.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= 32'hA5A5_0000 + rptr;
      rptr      <= rptr + 1;
    end
  end

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_last <= mem_wdata;
    end
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (tx_valid && tx_ready) acc_words.push_back(tx_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] d);
    wrSize = 1'b1;
    config_data = d;
    tick();
    wrSize = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  initial begin
    // ---------------- reset values ----------------
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    tick();

    // ---------------- reset mid-DELAY (D=10) ----------------
    cfg(32'h000A_0000);
    arm = 1'b1; tick(); arm = 1'b0;
    run = 1'b1; sti_valid = 1'b1; sti_data = 32'h11; tick(); run = 1'b0;
    sti_data = 32'h12; tick();
    sti_data = 32'h13; tick();
    sti_valid = 1'b0;
    check("dly_busy", busy, 1'b1);
    check("dly_third_wr", mem_wr, 1'b1);
    rst = 1'b1; #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_mem_wr", mem_wr, 1'b0);
    check("midrst_tx_valid", tx_valid, 1'b0);
    tick(); rst = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    check("rearm_busy", busy, 1'b1);
    sti_valid = 1'b1; sti_data = 32'h21; tick(); sti_valid = 1'b0;
    check("rearm_wr", mem_wr, 1'b1);
    check("rearm_wdata", mem_wdata, 32'h21);
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // ---------------- basic capture D=3 R=1 ----------------
    cfg(32'h0003_0001);
    w0 = wr_cnt; r0 = rd_cnt; a0 = acc_words.size();
    arm = 1'b1; tick(); arm = 1'b0;
    check("basic_busy", busy, 1'b1);
    sti_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin sti_data = 32'h100 + i; tick(); end
    run = 1'b1; sti_data = 32'h200; tick(); run = 1'b0;
    for (int i = 1; i < 4; i++) begin sti_data = 32'h200 + i; tick(); end
    sti_data = 32'h2FF; tick();
    sti_valid = 1'b0; tx_ready = 1'b1;
    wait_idle(40);
    tx_ready = 1'b0;
    check("basic_writes", wr_cnt - w0, 9);
    check("basic_last_wdata", wr_last, 32'h203);
    check("basic_reads", rd_cnt - r0, 2);
    check("basic_accepts", acc_words.size() - a0, 2);
    check("basic_word0", acc_words[a0], 32'hA5A5_0000);
    check("basic_word1", acc_words[a0+1], 32'hA5A5_0001);

    // ---------------- gapped valid D=2 R=0 ----------------
    cfg(32'h0002_0000);
    w0 = wr_cnt; r0 = rd_cnt; a0 = acc_words.size();
    arm = 1'b1; tick(); arm = 1'b0;
    sti_valid = 1'b1; sti_data = 32'h300; tick();
    run = 1'b1; sti_data = 32'h301; tick(); run = 1'b0;
    sti_valid = 1'b0; tick();
    check("gap_idle0", mem_wr, 1'b0);
    sti_valid = 1'b1; sti_data = 32'h302; tick();
    check("gap_wr1", mem_wr, 1'b1);
    sti_valid = 1'b0; tick();
    check("gap_idle1", mem_wr, 1'b0);
    sti_valid = 1'b1; sti_data = 32'h303; tick();
    check("gap_wr2", mem_wr, 1'b1);
    check("gap_wdata2", mem_wdata, 32'h303);
    sti_data = 32'h304; tick(); sti_valid = 1'b0;
    check("gap_exit_nowr", mem_wr, 1'b0);
    tx_ready = 1'b1;
    wait_idle(40);
    tx_ready = 1'b0;
    check("gap_writes", wr_cnt - w0, 4);
    check("gap_reads", rd_cnt - r0, 1);
    check("gap_word", acc_words[a0], 32'hA5A5_0002);

    // ---------------- backpressure D=0 R=0 ----------------
    cfg(32'h0000_0000);
    r0 = rd_cnt; a0 = acc_words.size();
    arm = 1'b1; tick(); arm = 1'b0;
    run = 1'b1; sti_valid = 1'b1; sti_data = 32'h400; tick();
    run = 1'b0; sti_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      check("bp_valid", tx_valid, 1'b1);
      check("bp_data", tx_data, 32'hA5A5_0003);
      if (i != 7) tick();
    end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    check("bp_valid_drop", tx_valid, 1'b0);
    check("bp_idle", busy, 1'b0);
    check("bp_accepts", acc_words.size() - a0, 1);
    check("bp_reads", rd_cnt - r0, 1);

    // ---------------- ignored events D=1 R=1 ----------------
    cfg(32'h0001_0001);
    w0 = wr_cnt; r0 = rd_cnt; a0 = acc_words.size();
    arm = 1'b1; tick(); arm = 1'b0;
    wrSize = 1'b1; config_data = 32'hFFFF_FFFF;
    run = 1'b1; sti_valid = 1'b1; sti_data = 32'h500; tick();
    sti_valid = 1'b0; tick();
    run = 1'b0; wrSize = 1'b0;
    sti_valid = 1'b1; sti_data = 32'h501; tick();
    sti_valid = 1'b0;
    tick();
    tick();
    check("ign_xmit_valid", tx_valid, 1'b1);
    arm = 1'b1; tick(); arm = 1'b0;
    check("ign_arm_busy", busy, 1'b1);
    check("ign_arm_valid", tx_valid, 1'b1);
    check("ign_arm_data", tx_data, 32'hA5A5_0004);
    tx_ready = 1'b1;
    wait_idle(100);
    tx_ready = 1'b0;
    check("ign_writes", wr_cnt - w0, 2);
    check("ign_reads", rd_cnt - r0, 2);
    check("ign_word1", acc_words[a0+1], 32'hA5A5_0005);

    // ---------------- boundary D=0xF R=0, arm+run in IDLE ----------------
    cfg(32'h000F_0000);
    w0 = wr_cnt; r0 = rd_cnt; a0 = acc_words.size();
    arm = 1'b1; run = 1'b1; sti_valid = 1'b1; sti_data = 32'h600; tick();
    arm = 1'b0;
    check("bnd_idle_nowr", mem_wr, 1'b0);
    check("bnd_busy", busy, 1'b1);
    sti_data = 32'h601; tick(); run = 1'b0;
    tx_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin sti_data = 32'h601 + i; tick(); end
    sti_valid = 1'b0;
    wait_idle(40);
    tx_ready = 1'b0;
    check("bnd_writes", wr_cnt - w0, 16);
    check("bnd_last_wdata", wr_last, 32'h610);
    check("bnd_reads", rd_cnt - r0, 1);
    check("bnd_accepts", acc_words.size() - a0, 1);
    check("bnd_word", acc_words[a0], 32'hA5A5_0006);

`ifdef CAPTURE_SEQUENCER_ABORT_EN
    // ---------------- abort with tx_ready in XMIT ----------------
    cfg(32'h0000_0001);
    r0 = rd_cnt;
    arm = 1'b1; tick(); arm = 1'b0;
    run = 1'b1; sti_valid = 1'b1; sti_data = 32'h700; tick();
    run = 1'b0; sti_valid = 1'b0;
    tick();
    tick();
    check("abt_xmit_valid", tx_valid, 1'b1);
    abort = 1'b1; tx_ready = 1'b1; arm = 1'b1; tick();
    abort = 1'b0; tx_ready = 1'b0; arm = 1'b0;
    check("abt_busy", busy, 1'b0);
    check("abt_valid", tx_valid, 1'b0);
    tick(); tick(); tick();
    check("abt_reads", rd_cnt - r0, 1);
    check("abt_still_idle", busy, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Capture-flow controller that sequences the sample memory around the trigger block's run output.
- On arm, streams valid samples into sample memory (pre-trigger fill).
- On run, counts a programmed number of post-trigger samples.
- Then reads back a programmed number of words from memory and hands them to the transmitter over a valid/ready handshake.
- Sits between the trigger, the sample memory and the serial transmitter.

Parameters:
DW, 32, sample/memory data width
CW, 16, width of delay and read counters; also the width of each config_data field

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
wrSize  input  1  load size register from config_data
config_data  input  32  [CW-1:0]=readCount, [CW+15:16]=delayCount
arm  input  1  start capture; honoured only in IDLE
run  input  1  trigger hit from trigger block; honoured only in SAMPLE
sti_valid  input  1  sample qualifier
sti_data  input  DW  sample data
mem_wr  output  1  sample memory write strobe
mem_wdata  output  DW  sample memory write data
mem_rd  output  1  sample memory read strobe; data returns exactly 1 cycle later
mem_rdata  input  DW  sample memory read data
tx_valid  output  1  readback word valid
tx_data  output  DW  readback word
tx_ready  input  1  transmitter accepts word
busy  output  1  high in every state except IDLE

Behaviour:
- Outputs registered. Reset values:
  - mem_wr=0, mem_rd=0, tx_valid=0, busy=0.
  - mem_wdata=0, tx_data=0.
  - Size fields=0, counters=0, state=IDLE.
- Reset mid-operation aborts immediately to IDLE. Memory contents are not cleared.
- wrSize is honoured only in IDLE. While busy=1 it is ignored and the fields keep their values.
- Count semantics:
  - delayCount=D stores D+1 post-trigger samples.
  - readCount=R reads back R+1 words.
  - Counters are CW-bit. Terminal condition is counter==field, so 0 means one sample/word and all-ones means 2^CW.
- IDLE: arm -> SAMPLE; counters cleared.
- SAMPLE:
  - Each cycle with sti_valid=1: mem_wr=1 and mem_wdata=sti_data on the next cycle (1-cycle latency).
  - run=1 -> DELAY. The sample present in that same cycle (if valid) is written and counts as post-trigger sample 0.
- DELAY:
  - Writes every valid sample as in SAMPLE; delay counter increments per written sample.
  - The write for which counter==delayCount is the last one -> READ.
  - run is ignored in DELAY.
- READ: mem_rd=1 for exactly one cycle -> RDWAIT.
- RDWAIT: one cycle; mem_rdata is captured into tx_data and tx_valid is set -> XMIT.
- XMIT:
  - tx_valid and tx_data are held stable until tx_ready=1.
  - On the cycle tx_ready=1 and tx_valid=1, the word is accepted and tx_valid drops next cycle.
  - If read counter==readCount -> IDLE; otherwise read counter increments -> READ.
- Minimum readback rate: 1 word per 3 cycles.
- Simultaneous events:
  - arm and run in IDLE: only arm acts (the run is ignored).
  - arm outside IDLE is ignored.
  - sti_valid in READ/RDWAIT/XMIT/IDLE produces no write.
- Memory address generation is owned by the memory block, which increments on mem_wr/mem_rd.

Optional Feature:
CAPTURE_SEQUENCER_ABORT_EN
- With the macro defined: adds input port abort (1 bit). abort=1 in any state forces IDLE on the next edge:
  - mem_wr, mem_rd, tx_valid cleared.
  - Counters cleared.
  - Size fields retained.
  - abort has priority over arm, run and tx_ready in the same cycle.
- Without the macro: no abort port; a capture can be terminated only by rst.

Test Plan:
- Reset: assert rst mid-DELAY (after 3 post-trigger writes, D=10) -> next cycle busy=0, mem_wr=0, tx_valid=0; a subsequent arm starts a fresh SAMPLE.
- Basic capture: config_data=0x0003_0001 (D=3, R=1), arm, 5 valid samples, run with valid -> exactly 4 post-trigger mem_wr pulses including the run-cycle sample, then 2 mem_rd pulses; tx words equal mem_rdata; back to IDLE, busy=0.
- Gapped valid: D=2, sti_valid toggling 1/0 after run -> exactly 3 mem_wr pulses spaced by invalid cycles; DELAY exit after the 3rd write.
- Backpressure: R=0, tx_ready low for 7 cycles -> tx_valid and tx_data stable for 8 cycles; single accept; IDLE next cycle.
- Ignored events: wrSize with 0xFFFF_FFFF while busy -> fields unchanged; arm in XMIT -> no effect; run in DELAY -> counter unaffected.
- Boundary (CW=4 build): D=0xF -> exactly 16 post-trigger writes; R=0 -> exactly 1 word. With CAPTURE_SEQUENCER_ABORT_EN: abort together with tx_ready in XMIT -> IDLE, no further mem_rd.
